// File: rtl/cd_101.sv
// Moore detector for the serial pattern 1,0,1 on signal; out is high while in DETECT.
// OVERLAP selects whether the final '1' of a match may start the next match.
module cd_101 #(
  parameter int OVERLAP = 1
) (
  input  logic clk,
  input  logic signal,
  output logic out,
  input  logic rst
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  state_t state;

  function automatic state_t next_state(input state_t cur, input logic bit_in);
    state_t nxt;
    nxt = S0;
    case (cur)
      S0: nxt = bit_in ? S1 : S0;
      S1: nxt = bit_in ? S1 : S2;
      S2: nxt = bit_in ? S3 : S0;
      // After a match, a trailing '0' either continues "10" or restarts.
      S3: nxt = bit_in ? S1 : ((OVERLAP != 0) ? S2 : S0);
      default: nxt = S0;
    endcase
    return nxt;
  endfunction

  // Registered state and output: out tracks the state being entered, so it
  // equals (state == S3) with no combinational path from signal.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S0;
      out   <= 1'b0;
    end else begin
      state <= next_state(state, signal);
      out   <= (next_state(state, signal) == S3);
    end
  end

endmodule

// File: tb/tb_cd_101.sv
// Bench for cd_101: one overlapping and one non-overlapping instance share stimulus
// and are compared against a history-based pattern model.
module tb_cd_101;

  logic clk;
  logic signal;
  logic rst;
  logic out_ov;
  logic out_no;

  int tests;
  int fails;

  // Reference model: bits since reset, last three bits, distance from last
  // non-overlapping match.
  int         since_rst;
  int         since_det;
  logic [2:0] last3;
  logic       exp_ov;
  logic       exp_no;

  cd_101 #(.OVERLAP(1)) dut_ov (
    .clk    (clk),
    .signal (signal),
    .out    (out_ov),
    .rst    (rst)
  );

  cd_101 #(.OVERLAP(0)) dut_no (
    .clk    (clk),
    .signal (signal),
    .out    (out_no),
    .rst    (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one bit before a rising edge, sample after it, and advance the model.
  task automatic clock_in(input logic s, input logic r);
    logic hit;
    @(negedge clk);
    signal = s;
    rst    = r;
    @(posedge clk);
    #1;
    if (r) begin
      since_rst = 0;
      since_det = 100;
      last3     = 3'b000;
      exp_ov    = 1'b0;
      exp_no    = 1'b0;
    end else begin
      last3     = {last3[1:0], s};
      since_rst = since_rst + 1;
      since_det = since_det + 1;
      hit       = (since_rst >= 3) && (last3 == 3'b101);
      exp_ov    = hit;
      exp_no    = hit && (since_det >= 3);
      if (exp_no) since_det = 0;
    end
  endtask

  task automatic apply_reset(input int n);
    for (int i = 0; i < n; i++) clock_in(1'b0, 1'b1);
  endtask

  task automatic test_reset();
    apply_reset(2);
    tests++;
    if (out_ov !== 1'b0) begin
      fails++;
      $display("FAIL reset_ov: out=%b expected 0", out_ov);
    end
    tests++;
    if (out_no !== 1'b0) begin
      fails++;
      $display("FAIL reset_no: out=%b expected 0", out_no);
    end
  endtask

  task automatic test_basic();
    logic [3:0] bits;
    logic [3:0] exp;
    bits = 4'b1101;
    exp  = 4'b0001;
    apply_reset(2);
    for (int i = 3; i >= 0; i--) begin
      clock_in(bits[i], 1'b0);
      tests++;
      if (out_ov !== exp[i]) begin
        fails++;
        $display("FAIL basic_ov[%0d]: out=%b expected %b", 3 - i, out_ov, exp[i]);
      end
      tests++;
      if (out_no !== exp[i]) begin
        fails++;
        $display("FAIL basic_no[%0d]: out=%b expected %b", 3 - i, out_no, exp[i]);
      end
    end
  endtask

  task automatic test_overlap();
    logic [5:0] bits;
    logic [5:0] exp_o;
    logic [5:0] exp_n;
    bits  = 6'b101010;
    exp_o = 6'b001010;
    exp_n = 6'b001000;
    apply_reset(1);
    for (int i = 5; i >= 0; i--) begin
      clock_in(bits[i], 1'b0);
      tests++;
      if (out_ov !== exp_o[i]) begin
        fails++;
        $display("FAIL overlap_ov[%0d]: out=%b expected %b", 5 - i, out_ov, exp_o[i]);
      end
      tests++;
      if (out_no !== exp_n[i]) begin
        fails++;
        $display("FAIL overlap_no[%0d]: out=%b expected %b", 5 - i, out_no, exp_n[i]);
      end
    end
  endtask

  task automatic test_nonoverlap_repeat();
    logic [5:0] bits;
    logic [5:0] exp_n;
    bits  = 6'b101101;
    exp_n = 6'b001001;
    apply_reset(1);
    for (int i = 5; i >= 0; i--) begin
      clock_in(bits[i], 1'b0);
      tests++;
      if (out_no !== exp_n[i]) begin
        fails++;
        $display("FAIL repeat_no[%0d]: out=%b expected %b", 5 - i, out_no, exp_n[i]);
      end
    end
  endtask

  task automatic test_no_false();
    logic [6:0]  bits;
    logic [13:0] path;
    logic [1:0]  st;
    logic [1:0]  want;
    bits = 7'b1001100;
    path = {2'd1, 2'd2, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0};
    apply_reset(1);
    for (int i = 6; i >= 0; i--) begin
      clock_in(bits[i], 1'b0);
      tests++;
      if (out_ov !== 1'b0 || out_no !== 1'b0) begin
        fails++;
        $display("FAIL nofalse_out[%0d]: out=%b/%b expected 0/0", 6 - i, out_ov, out_no);
      end
      st   = dut_ov.state;
      want = path[2*i +: 2];
      tests++;
      if (st !== want) begin
        fails++;
        $display("FAIL nofalse_state[%0d]: state=%0d expected %0d", 6 - i, st, want);
      end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset(1);
    clock_in(1'b1, 1'b0);
    clock_in(1'b0, 1'b0);
    clock_in(1'b1, 1'b1);
    tests++;
    if (out_ov !== 1'b0) begin
      fails++;
      $display("FAIL midrst_hold: out=%b expected 0", out_ov);
    end
    clock_in(1'b1, 1'b0);
    tests++;
    if (out_ov !== 1'b0 || out_no !== 1'b0) begin
      fails++;
      $display("FAIL midrst_first1: out=%b/%b expected 0/0", out_ov, out_no);
    end
    clock_in(1'b0, 1'b0);
    clock_in(1'b1, 1'b0);
    tests++;
    if (out_ov !== 1'b1 || out_no !== 1'b1) begin
      fails++;
      $display("FAIL midrst_detect: out=%b/%b expected 1/1", out_ov, out_no);
    end
  endtask

  task automatic test_reset_detect();
    logic [2:0] tog;
    tog = 3'b101;
    apply_reset(1);
    clock_in(1'b1, 1'b0);
    clock_in(1'b0, 1'b0);
    clock_in(1'b1, 1'b0);
    tests++;
    if (out_ov !== 1'b1) begin
      fails++;
      $display("FAIL rstdet_pre: out=%b expected 1", out_ov);
    end
    clock_in(1'b0, 1'b1);
    tests++;
    if (out_ov !== 1'b0 || out_no !== 1'b0) begin
      fails++;
      $display("FAIL rstdet_clear: out=%b/%b expected 0/0", out_ov, out_no);
    end
    for (int i = 2; i >= 0; i--) begin
      clock_in(tog[i], 1'b1);
      tests++;
      if (out_ov !== 1'b0 || out_no !== 1'b0) begin
        fails++;
        $display("FAIL rstdet_held[%0d]: out=%b/%b expected 0/0", 2 - i, out_ov, out_no);
      end
    end
  endtask

  task automatic test_random();
    int bad_ov;
    int bad_no;
    bad_ov = 0;
    bad_no = 0;
    apply_reset(1);
    for (int i = 0; i < 200; i++) begin
      clock_in(1'($urandom_range(0, 1)), 1'b0);
      tests++;
      if (out_ov !== exp_ov) begin
        fails++;
        bad_ov++;
        $display("FAIL random_ov[%0d]: out=%b expected %b", i, out_ov, exp_ov);
      end
      tests++;
      if (out_no !== exp_no) begin
        fails++;
        bad_no++;
        $display("FAIL random_no[%0d]: out=%b expected %b", i, out_no, exp_no);
      end
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    since_rst = 0;
    since_det = 100;
    last3     = 3'b000;
    exp_ov    = 1'b0;
    exp_no    = 1'b0;
    signal    = 1'b0;
    rst       = 1'b1;
    test_reset();
    test_basic();
    test_overlap();
    test_nonoverlap_repeat();
    test_no_false();
    test_mid_reset();
    test_reset_detect();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
